// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin 8N1 UART transmitter
module uart_tx_sched #(
  parameter logic [15:0] BAUD_DIV = 16'd10417
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        div_wr,
  input  logic [15:0] div_val,
  output logic        tx,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] divisor;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        prio;
  logic        tx_q;
  logic        gsel;
  logic        accept;
  logic        bit_end;

  // A lone valid requester wins; on contention the priority holder wins.
  always_comb begin
    gsel = prio;
    if (req0_valid && !req1_valid)      gsel = 1'b0;
    else if (req1_valid && !req0_valid) gsel = 1'b1;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !gsel;
  assign req1_ready = accept && gsel;
  assign bit_end    = (cnt == divisor);
  assign busy       = (state != IDLE);
  assign tx         = tx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor  <= BAUD_DIV;
      cnt      <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      prio     <= 1'b0;
      tx_q     <= 1'b1;
      grant_id <= 1'b0;
    end else begin
      // Divisor only moves in IDLE, so a frame always runs on one bit period.
      if (state == IDLE && div_wr) divisor <= div_val;
      if (accept) begin
        shreg    <= gsel ? req1_data : req0_data;
        grant_id <= gsel;
        prio     <= ~gsel;
        cnt      <= 16'd0;
        bit_idx  <= 3'd0;
        tx_q     <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? 16'd0 : cnt + 16'd1;
        if (bit_end) begin
          // shreg[0] always holds the next data bit to drive.
          case (state)
            START: begin
              tx_q  <= shreg[0];
              shreg <= shreg >> 1;
            end
            DATA: begin
              if (bit_idx == 3'd7) begin
                tx_q <= 1'b1;
              end else begin
                tx_q    <= shreg[0];
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
              end
            end
            default: tx_q <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int BAUD = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'd0;
  logic        req1_ready;
  logic        div_wr = 1'b0;
  logic [15:0] div_val = 16'd0;
  logic        tx;
  logic        busy;
  logic        grant_id;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         p;
    logic       gid;
    bit         abort;
    int         gap;
  } frame_t;

  frame_t exp_q[$];

  uart_tx_sched #(.BAUD_DIV(16'(BAUD))) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .div_wr     (div_wr),
    .div_val    (div_val),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input logic [7:0] d, input int p, input logic g,
                               input bit ab, input int gap);
    frame_t f;
    f.data = d; f.p = p; f.gid = g; f.abort = ab; f.gap = gap;
    exp_q.push_back(f);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit who, input logic [7:0] d, input bit dw, input logic [15:0] dv);
    bit done = 0;
    if (who) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    div_wr = dw; div_val = dv;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) done = 1;
    end
    check(done, "accept_timeout", done, 1);
    tick();
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
    div_wr = 1'b0;
  endtask

  task automatic hold_both(input logic [7:0] d0, input logic [7:0] d1, input int n);
    int cnt = 0;
    req0_valid = 1'b1; req0_data = d0;
    req1_valid = 1'b1; req1_data = d1;
    for (int i = 0; i < 1000 && cnt < n; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) cnt++;
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check(cnt == n, "contended_accepts", cnt, n);
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    check(seen, "idle_timeout", seen, 1);
    tick();
  endtask

  // Frame monitor: decodes every frame on tx against the next expected record.
  initial begin : monitor
    frame_t r;
    bit     prev_busy = 0;
    int     last_start = 0;
    bit     bad[10];
    bit     aborted;
    int     k;
    logic   e;
    forever begin
      @(negedge clk);
      if (reset_n && busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected_frame", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check(grant_id == r.gid, "grant_id", grant_id, r.gid);
          if (r.gap != 0) check(cyc - last_start == r.gap, "frame_spacing", cyc - last_start, r.gap);
          last_start = cyc;
          foreach (bad[j]) bad[j] = 0;
          aborted = 0;
          for (int i = 0; i < 10 * r.p; i++) begin
            if (i > 0) @(negedge clk);
            if (!reset_n) begin
              aborted = 1;
              break;
            end
            k = i / r.p;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : r.data[k-1];
            if (tx !== e || busy !== 1'b1) bad[k] = 1;
          end
          if (aborted) begin
            check(r.abort, "frame_aborted_unexpectedly", 1, 0);
          end else begin
            for (int b = 0; b < 10; b++)
              check(!bad[b], $sformatf("tx_bit%0d_byte%02h_mismatch", b, r.data), bad[b], 0);
            if (r.abort) check(0, "abort_missed", 0, 1);
            @(negedge clk);
            check(busy == 1'b0, "busy_after_stop", busy, 0);
          end
        end
      end
      prev_busy = busy;
    end
  end

  always @(negedge clk) begin
    if (reset_n)
      check(!(req0_ready && req1_ready)
            && (!req0_ready || (req0_valid && !busy))
            && (!req1_ready || (req1_valid && !busy)),
            "ready_rule", {req0_ready, req1_ready}, 0);
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check(tx == 1'b1, "reset_tx", tx, 1);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(grant_id == 1'b0, "reset_grant_id", grant_id, 0);
    reset_n = 1'b1;
    tick();

    // 0xA5 with divisor 3 written in the acceptance cycle
    push(8'hA5, 4, 1'b0, 0, 0);
    send(1'b0, 8'hA5, 1'b1, 16'd3);
    wait_idle();

    // both valid from reset: 0,1,0 each 41 cycles apart
    reset_n = 1'b0;
    tick();
    div_wr = 1'b1; div_val = 16'd3;
    reset_n = 1'b1;
    push(8'h11, 4, 1'b0, 0, 0);
    push(8'h22, 4, 1'b1, 0, 41);
    push(8'h11, 4, 1'b0, 0, 41);
    hold_both(8'h11, 8'h22, 3);
    div_wr = 1'b0;
    wait_idle();

    // divisor write mid-frame ignored; write in IDLE takes effect
    push(8'h3C, 4, 1'b0, 0, 0);
    send(1'b0, 8'h3C, 1'b0, 16'd0);
    repeat (5) tick();
    div_wr = 1'b1; div_val = 16'd7;
    tick();
    div_wr = 1'b0;
    push(8'hC3, 4, 1'b1, 0, 41);
    send(1'b1, 8'hC3, 1'b0, 16'd0);
    wait_idle();
    div_wr = 1'b1; div_val = 16'd7;
    tick();
    div_wr = 1'b0;
    push(8'h5A, 8, 1'b0, 0, 0);
    send(1'b0, 8'h5A, 1'b0, 16'd0);
    wait_idle();

    // divisor 0 written together with acceptance of 0xFF
    push(8'hFF, 1, 1'b0, 0, 0);
    send(1'b0, 8'hFF, 1'b1, 16'd0);
    wait_idle();

    // reset during data bit 3
    div_wr = 1'b1; div_val = 16'd3;
    tick();
    div_wr = 1'b0;
    push(8'h96, 4, 1'b0, 1, 0);
    send(1'b0, 8'h96, 1'b0, 16'd0);
    repeat (17) tick();
    #2;
    reset_n = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h4B;
    #1;
    check(tx == 1'b1, "abort_tx_high", tx, 1);
    check(busy == 1'b0, "abort_busy_low", busy, 0);
    push(8'h4B, BAUD + 1, 1'b1, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check(busy == 1'b1, "first_edge_accept_busy", busy, 1);
    check(grant_id == 1'b1, "first_edge_accept_grant", grant_id, 1);
    req1_valid = 1'b0;
    wait_idle();

    // req1 pulse while busy is never accepted and does not move priority
    push(8'h81, BAUD + 1, 1'b0, 0, 0);
    send(1'b0, 8'h81, 1'b0, 16'd0);
    repeat (2) tick();
    req1_valid = 1'b1; req1_data = 8'h77;
    @(negedge clk);
    check(req1_ready == 1'b0, "req1_ready_while_busy", req1_ready, 0);
    tick();
    req1_valid = 1'b0;
    wait_idle();
    push(8'hF0, BAUD + 1, 1'b1, 0, 0);
    push(8'h0F, BAUD + 1, 1'b0, 0, 10 * (BAUD + 1) + 1);
    hold_both(8'h0F, 8'hF0, 2);
    wait_idle();

    repeat (5) tick();
    check(exp_q.size() == 0, "frames_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter BAUD_DIV, default 10417: reset value of the divisor register; one bit period = divisor+1 clk cycles.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_data  input  8  requester 0 byte; sampled on acceptance.
REQ-006 req0_ready  output  1  requester 0 byte accepted this cycle when req0_valid is also high.
REQ-007 req1_valid  input  1  requester 1 has a byte to send.
REQ-008 req1_data  input  8  requester 1 byte; sampled on acceptance.
REQ-009 req1_ready  output  1  requester 1 byte accepted this cycle when req1_valid is also high.
REQ-010 div_wr  input  1  divisor write strobe.
REQ-011 div_val  input  16  new divisor value.
REQ-012 tx  output  1  serial line, registered, idle high.
REQ-013 busy  output  1  high while a frame is in progress.
REQ-014 grant_id  output  1  index of the most recently accepted requester.

Function
REQ-015 The block SHALL share one UART transmitter between two requesters, sequencing 8N1 frames with an internal bit-period counter.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-017 In IDLE, the grant SHALL go to the only valid requester, or to the round-robin priority holder when both are valid.
REQ-018 reqN_ready SHALL be combinational: high only in IDLE for the granted requester with its valid high; at most one ready high per cycle.
REQ-019 Acceptance (valid&ready) in cycle N SHALL latch the data, set grant_id, move priority to the other requester, clear the bit counter, and enter START at edge N+1.
REQ-020 tx SHALL be 0 for the start bit, then data bits LSB first, then 1 for the stop bit; each bit lasts exactly divisor+1 cycles.
REQ-021 The bit counter SHALL count 0..divisor, and at divisor advance bit/state and wrap to 0; a 3-bit index SHALL track data bits 0..7.
REQ-022 After the stop bit completes, the FSM SHALL return to IDLE; a waiting requester SHALL be accepted in that first IDLE cycle, giving a back-to-back frame period of 10*(divisor+1)+1 cycles.
REQ-023 div_wr in IDLE SHALL load div_val at the next edge; if it coincides with an acceptance, the new value SHALL apply to that frame.
REQ-024 div_wr while busy SHALL be ignored; the divisor SHALL never change mid-frame.
REQ-025 div_val = 0 SHALL be legal, giving a 1-cycle bit period.
REQ-026 A requester dropping valid before acceptance SHALL forfeit nothing; priority SHALL change only on acceptance.
REQ-027 Requester data SHALL NOT be sampled outside the acceptance cycle.

Reset
REQ-028 On reset_n low, the block SHALL immediately force: tx=1, busy=0, state IDLE, grant_id=0, priority to requester 0, divisor=BAUD_DIV, counters 0.
REQ-029 Reset mid-frame SHALL abort the frame with no resumption; the aborted byte SHALL be lost.
REQ-030 After reset release, the first rising edge SHALL be able to accept a request.

Verification
REQ-031 divisor=3, req0 sends 0xA5 -> tx low 4 cycles starting edge after accept, then 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles; busy 40 cycles; grant_id=0.
REQ-032 Both valid from reset, bytes 0x11/0x22, held -> accepts req0 then req1 then req0; frames 41 cycles apart; grant_id alternates 0,1,0.
REQ-033 div_wr=1, div_val=7 mid-frame (divisor=3) -> current and next frames keep 4-cycle bits; div_wr in IDLE -> next frame uses 8-cycle bits.
REQ-034 div_wr with div_val=0 in the same cycle as acceptance of 0xFF -> frame is 10 cycles (start 1 cycle, eight 1s, stop); busy 10 cycles.
REQ-035 reset_n pulsed low during data bit 3 -> tx=1 and busy=0 immediately; after release, req1 alone valid is accepted at the first edge; divisor back to BAUD_DIV.
REQ-036 req1_valid pulsed for one cycle while busy, then dropped -> never accepted; req1_ready stays 0; priority unchanged.
